// File: rtl/pixel_fb_writer.sv
// Pixel-stream sink: buffers rasterizer beats in a small FIFO and writes them to the framebuffer.
// Also sweeps the whole framebuffer with a fill colour on request.
module pixel_fb_writer #(
    parameter int unsigned COORD_WIDTH = 16,
    parameter int unsigned COLOR_WIDTH = 8,
    parameter int unsigned FB_WIDTH    = 320,
    parameter int unsigned FB_HEIGHT   = 180,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned SLACK       = 3,
    localparam int unsigned ADDR_WIDTH = $clog2(FB_WIDTH * FB_HEIGHT)
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic signed [COORD_WIDTH-1:0] x_in,
    input  logic signed [COORD_WIDTH-1:0] y_in,
    input  logic                          pixel_valid,
    input  logic [COLOR_WIDTH-1:0]        color_in,
    output logic                          oe_out,
    input  logic                          start_clear,
    input  logic [COLOR_WIDTH-1:0]        clear_color,
    output logic [ADDR_WIDTH-1:0]         fb_addr,
    output logic [COLOR_WIDTH-1:0]        fb_data,
    output logic                          fb_we,
    input  logic                          fb_ready,
    output logic                          busy,
    output logic                          clear_done,
    output logic                          overflow
);

    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW   = PtrW + 1;
    localparam int unsigned EntryW = 2 * COORD_WIDTH + COLOR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(FB_WIDTH * FB_HEIGHT - 1);
    localparam logic signed [COORD_WIDTH-1:0] XLimit = COORD_WIDTH'(FB_WIDTH);
    localparam logic signed [COORD_WIDTH-1:0] YLimit = COORD_WIDTH'(FB_HEIGHT);
    localparam logic [CntW-1:0] FullCnt  = CntW'(FIFO_DEPTH);
    localparam logic [CntW-1:0] OeThresh = CntW'(FIFO_DEPTH - SLACK);

    typedef enum logic [1:0] {StWrite, StClearWait, StClear, StClearDone} state_e;

    state_e                  state_q, state_d;
    logic [EntryW-1:0]       mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]         count_q, count_d;
    logic                    push_q;
    logic                    fb_we_q, fb_we_d;
    logic [ADDR_WIDTH-1:0]   fb_addr_q, fb_addr_d;
    logic [COLOR_WIDTH-1:0]  fb_data_q, fb_data_d;
    logic [ADDR_WIDTH-1:0]   clear_addr_q, clear_addr_d;
    logic [COLOR_WIDTH-1:0]  clear_color_q, clear_color_d;
    logic                    oe_q, busy_q, clear_done_q, overflow_q;

    logic                          push, pop, head_ready, load_ok, head_in_range;
    logic signed [COORD_WIDTH-1:0] head_x, head_y;
    logic [COLOR_WIDTH-1:0]        head_color;
    logic [ADDR_WIDTH-1:0]         pix_addr;

    assign push    = pixel_valid && (count_q != FullCnt);
    assign load_ok = !fb_we_q || fb_ready;
    // The entry written on the previous edge is not yet readable, as with a registered-read RAM.
    assign head_ready = count_q > CntW'(push_q);

    assign {head_x, head_y, head_color} = mem_q[rd_ptr_q];
    assign head_in_range = !head_x[COORD_WIDTH-1] && (head_x < XLimit) &&
                           !head_y[COORD_WIDTH-1] && (head_y < YLimit);
    assign pix_addr = ADDR_WIDTH'($unsigned(head_y)) * ADDR_WIDTH'(FB_WIDTH) +
                      ADDR_WIDTH'($unsigned(head_x));

    always_comb begin
        state_d       = state_q;
        fb_we_d       = fb_we_q;
        fb_addr_d     = fb_addr_q;
        fb_data_d     = fb_data_q;
        clear_addr_d  = clear_addr_q;
        clear_color_d = clear_color_q;
        pop           = 1'b0;
        if (load_ok) begin
            fb_we_d = 1'b0;
        end
        unique case (state_q)
            StWrite: begin
                if (start_clear) begin
                    state_d       = StClearWait;
                    clear_color_d = clear_color;
                end
                if (load_ok && head_ready) begin
                    pop = 1'b1;
                    if (head_in_range) begin
                        fb_we_d   = 1'b1;
                        fb_addr_d = pix_addr;
                        fb_data_d = head_color;
                    end
                end
            end
            StClearWait: begin
                if (!fb_we_q) begin
                    state_d      = StClear;
                    clear_addr_d = '0;
                end
            end
            StClear: begin
                if (fb_we_q && fb_ready && (fb_addr_q == LastAddr)) begin
                    state_d = StClearDone;
                end else if (load_ok) begin
                    fb_we_d      = 1'b1;
                    fb_addr_d    = clear_addr_q;
                    fb_data_d    = clear_color_q;
                    clear_addr_d = clear_addr_q + ADDR_WIDTH'(1);
                end
            end
            StClearDone: begin
                state_d = StWrite;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {x_in, y_in, color_in};
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= StWrite;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            push_q        <= 1'b0;
            fb_we_q       <= 1'b0;
            fb_addr_q     <= '0;
            fb_data_q     <= '0;
            clear_addr_q  <= '0;
            clear_color_q <= '0;
            oe_q          <= 1'b0;
            busy_q        <= 1'b0;
            clear_done_q  <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            push_q        <= push;
            fb_we_q       <= fb_we_d;
            fb_addr_q     <= fb_addr_d;
            fb_data_q     <= fb_data_d;
            clear_addr_q  <= clear_addr_d;
            clear_color_q <= clear_color_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (pixel_valid && (count_q == FullCnt)) begin
                overflow_q <= 1'b1;
            end
            oe_q         <= (count_d <= OeThresh) && (state_d == StWrite);
            busy_q       <= (count_d != '0) || fb_we_d || (state_d != StWrite);
            clear_done_q <= (state_d == StClearDone);
        end
    end

    assign oe_out     = oe_q;
    assign fb_we      = fb_we_q;
    assign fb_addr    = fb_addr_q;
    assign fb_data    = fb_data_q;
    assign busy       = busy_q;
    assign clear_done = clear_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Directed bench for pixel_fb_writer: a 320x180 instance for the pixel path and a 4x2 instance
// for the clear sweep.
module tb_pixel_fb_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [15:0] x_a, y_a;
    logic        valid_a, start_a, ready_a;
    logic [7:0]  color_a, ccol_a;
    logic        oe_a, we_a, busy_a, done_a, ovf_a;
    logic [15:0] addr_a;
    logic [7:0]  data_a;

    logic [15:0] x_b, y_b;
    logic        valid_b, start_b, ready_b;
    logic [7:0]  color_b, ccol_b;
    logic        oe_b, we_b, busy_b, done_b, ovf_b;
    logic [2:0]  addr_b;
    logic [7:0]  data_b;

    pixel_fb_writer u_dut_a (
        .clk_in      (clk),
        .rst_in      (rst),
        .x_in        (x_a),
        .y_in        (y_a),
        .pixel_valid (valid_a),
        .color_in    (color_a),
        .oe_out      (oe_a),
        .start_clear (start_a),
        .clear_color (ccol_a),
        .fb_addr     (addr_a),
        .fb_data     (data_a),
        .fb_we       (we_a),
        .fb_ready    (ready_a),
        .busy        (busy_a),
        .clear_done  (done_a),
        .overflow    (ovf_a)
    );

    pixel_fb_writer #(
        .FB_WIDTH  (4),
        .FB_HEIGHT (2)
    ) u_dut_b (
        .clk_in      (clk),
        .rst_in      (rst),
        .x_in        (x_b),
        .y_in        (y_b),
        .pixel_valid (valid_b),
        .color_in    (color_b),
        .oe_out      (oe_b),
        .start_clear (start_b),
        .clear_color (ccol_b),
        .fb_addr     (addr_b),
        .fb_data     (data_b),
        .fb_we       (we_b),
        .fb_ready    (ready_b),
        .busy        (busy_b),
        .clear_done  (done_b),
        .overflow    (ovf_b)
    );

    int tests = 0;
    int fails = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int ncomp;
        int ndone;
        int nwr;
        logic found;
        logic [15:0] xs [4];
        logic [15:0] ys [4];

        rst = 1'b1;
        x_a = '0; y_a = '0; valid_a = 1'b0; color_a = '0; start_a = 1'b0; ccol_a = '0;
        ready_a = 1'b0;
        x_b = '0; y_b = '0; valid_b = 1'b0; color_b = '0; start_b = 1'b0; ccol_b = '0;
        ready_b = 1'b0;
        tick();
        tick();
        check("rst_we", we_a, 0);
        check("rst_addr", addr_a, 0);
        check("rst_data", data_a, 0);
        check("rst_oe", oe_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_ovf", ovf_a, 0);
        check("rst_we_b", we_b, 0);
        check("rst_ovf_b", ovf_b, 0);
        rst = 1'b0;

        // Single beat (5,2): write appears two edges after the sampling edge.
        ready_a = 1'b1;
        x_a = 16'd5; y_a = 16'd2; color_a = 8'h3C; valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        check("lat_we_k", we_a, 0);
        check("lat_oe", oe_a, 1);
        check("lat_busy", busy_a, 1);
        tick();
        check("lat_we_k1", we_a, 0);
        tick();
        check("lat_we_k2", we_a, 1);
        check("lat_addr", addr_a, 645);
        check("lat_data", data_a, 8'h3C);
        tick();
        check("lat_we_k3", we_a, 0);
        check("lat_idle", busy_a, 0);

        // Backpressure: 9 beats, the last two arriving after oe_out has fallen.
        ready_a = 1'b0;
        for (int i = 0; i < 9; i++) begin
            x_a = 16'(i); y_a = 16'd1; color_a = 8'(16 + i); valid_a = 1'b1;
            tick();
            check("bp_oe", oe_a, (i < 6) ? 1 : 0);
        end
        valid_a = 1'b0;
        check("bp_ovf", ovf_a, 0);
        check("bp_we", we_a, 1);
        check("bp_addr0", addr_a, 320);
        tick();
        tick();
        check("bp_hold_addr", addr_a, 320);
        check("bp_hold_data", data_a, 8'h10);
        ready_a = 1'b1;
        for (int i = 1; i < 9; i++) begin
            tick();
            check("bp_drain_we", we_a, 1);
            check("bp_drain_addr", addr_a, 320 + i);
            check("bp_drain_data", data_a, 16 + i);
        end
        tick();
        check("bp_end_we", we_a, 0);
        check("bp_end_busy", busy_a, 0);
        check("bp_end_oe", oe_a, 1);

        // Out-of-range beats are dropped; the corner pixel is written.
        xs[0] = 16'd320; ys[0] = 16'd0;
        xs[1] = 16'hFFFF; ys[1] = 16'd5;
        xs[2] = 16'd0; ys[2] = 16'd180;
        xs[3] = 16'd319; ys[3] = 16'd179;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                x_a = xs[i]; y_a = ys[i]; color_a = 8'(i + 1); valid_a = 1'b1;
            end else begin
                valid_a = 1'b0;
            end
            tick();
            check("rng_we", we_a, (i == 5) ? 1 : 0);
            if (i == 5) begin
                check("rng_addr", addr_a, 57599);
                check("rng_data", data_a, 4);
            end
        end
        tick();
        check("rng_end_we", we_a, 0);

        // Upstream ignores oe_out with the port stalled: the 10th beat overflows.
        ready_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            x_a = 16'(i); y_a = 16'd0; color_a = 8'(i); valid_a = 1'b1;
            tick();
            check("ovf_flag", ovf_a, (i == 9) ? 1 : 0);
        end
        valid_a = 1'b0;
        tick();
        tick();
        check("ovf_sticky", ovf_a, 1);
        ready_a = 1'b1;
        nwr = 0;
        for (int t = 0; t < 15; t++) begin
            if (we_a) nwr++;
            tick();
        end
        check("ovf_writes", nwr, 9);
        check("ovf_sticky2", ovf_a, 1);
        check("ovf_busy", busy_a, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("ovf_rst", ovf_a, 0);

        // Clear on the 4x2 instance with fb_ready toggling and a pixel arriving mid-clear.
        start_b = 1'b1; ccol_b = 8'hAA;
        tick();
        start_b = 1'b0; ccol_b = 8'h00;
        ncomp = 0;
        ndone = 0;
        for (int t = 0; t < 80 && ncomp < 9; t++) begin
            ready_b = t[0];
            valid_b = (t == 4); x_b = 16'd1; y_b = 16'd1; color_b = 8'h55;
            if (t == 6) check("clr_oe", oe_b, 0);
            if (done_b) begin
                ndone++;
                check("clr_done_pos", ncomp, 8);
            end
            if (we_b && ready_b) begin
                check("clr_addr", addr_b, (ncomp < 8) ? ncomp : 5);
                check("clr_data", data_b, (ncomp < 8) ? 8'hAA : 8'h55);
                ncomp++;
            end
            tick();
        end
        valid_b = 1'b0;
        check("clr_writes", ncomp, 9);
        check("clr_done_cnt", ndone, 1);

        // Reset while the clear sweep is writing address 3.
        ready_b = 1'b1;
        start_b = 1'b1; ccol_b = 8'h11;
        tick();
        start_b = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            if (we_b && addr_b == 3'd3) found = 1'b1;
            else tick();
        end
        check("rstclr_found", found, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstclr_we", we_b, 0);
        check("rstclr_busy", busy_b, 0);
        ndone = 0;
        nwr = 0;
        for (int t = 0; t < 20; t++) begin
            if (done_b) ndone++;
            if (we_b) nwr++;
            tick();
        end
        check("rstclr_no_done", ndone, 0);
        check("rstclr_no_we", nwr, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
